// File: rtl/rob_multi_cdb.sv
// Reorder buffer with N_CDB result lanes, operand lookup bypass and
// in-order single retire; a retiring mispredict flushes everything.
module rob_multi_cdb #(
  parameter int DEPTH = 16,
  parameter int N_CDB = 2,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [4:0]            iss_dr,
  input  logic                  iss_load_imm,
  input  logic [31:0]           iss_imm_val,
  input  logic                  iss_is_st,
  input  logic                  iss_is_br,
  input  logic                  iss_is_jump,
  output logic [IDXW-1:0]       iss_rob_idx,
  input  logic [N_CDB-1:0]      cdb_valid,
  input  logic [N_CDB*IDXW-1:0] cdb_rob_idx,
  input  logic [N_CDB*32-1:0]   cdb_val,
  input  logic                  br_valid,
  input  logic [IDXW-1:0]       br_rob_idx,
  input  logic                  br_mispredict,
  input  logic [31:0]           br_target_pc,
  input  logic [31:0]           br_link_val,
  input  logic [IDXW-1:0]       lk_idx_1,
  input  logic [IDXW-1:0]       lk_idx_2,
  output logic                  lk_valid_1,
  output logic                  lk_valid_2,
  output logic [31:0]           lk_val_1,
  output logic [31:0]           lk_val_2,
  output logic                  cmt_valid,
  output logic [4:0]            cmt_rd,
  output logic [31:0]           cmt_val,
  output logic [IDXW-1:0]       cmt_rob_idx,
  output logic                  cmt_is_st,
  output logic                  flush_all,
  output logic [31:0]           flush_pc,
  output logic [IDXW:0]         count
);

  logic [IDXW:0]   head_q, head_d;
  logic [IDXW:0]   tail_q, tail_d;
  logic            valid_q [DEPTH];
  logic            done_q  [DEPTH];
  logic            mis_q   [DEPTH];
  logic            st_q    [DEPTH];
  logic            br_q    [DEPTH];
  logic            jmp_q   [DEPTH];
  logic [4:0]      rd_q    [DEPTH];
  logic [31:0]     val_q   [DEPTH];
  logic [31:0]     tgt_q   [DEPTH];

  logic [IDXW-1:0] hidx, tidx;
  logic            full, alloc;

  assign hidx  = head_q[IDXW-1:0];
  assign tidx  = tail_q[IDXW-1:0];
  assign count = tail_q - head_q;
  assign full  = (count == (IDXW+1)'(DEPTH));

  assign cmt_valid   = valid_q[hidx] & done_q[hidx];
  assign flush_all   = cmt_valid & mis_q[hidx];
  assign flush_pc    = flush_all ? tgt_q[hidx] : 32'd0;
  assign cmt_rd      = cmt_valid ? rd_q[hidx] : 5'd0;
  assign cmt_val     = cmt_valid ? val_q[hidx] : 32'd0;
  assign cmt_is_st   = cmt_valid & st_q[hidx];
  assign cmt_rob_idx = hidx;

  assign iss_ready   = !full && !flush_all;
  assign iss_rob_idx = tidx;
  assign alloc       = iss_valid && iss_ready;

  // Lookup bypass: a lane writing the entry this cycle beats stored state
  always_comb begin
    lk_valid_1 = done_q[lk_idx_1];
    lk_val_1   = val_q[lk_idx_1];
    lk_valid_2 = done_q[lk_idx_2];
    lk_val_2   = val_q[lk_idx_2];
    for (int k = 0; k < N_CDB; k++) begin
      if (cdb_valid[k] && cdb_rob_idx[k*IDXW +: IDXW] == lk_idx_1) begin
        lk_valid_1 = 1'b1;
        lk_val_1   = cdb_val[k*32 +: 32];
      end
      if (cdb_valid[k] && cdb_rob_idx[k*IDXW +: IDXW] == lk_idx_2) begin
        lk_valid_2 = 1'b1;
        lk_val_2   = cdb_val[k*32 +: 32];
      end
    end
  end

  always_comb begin
    head_d = head_q + (IDXW+1)'(cmt_valid);
    tail_d = tail_q + (IDXW+1)'(alloc);
    if (flush_all) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        done_q[i]  <= 1'b0;
        mis_q[i]   <= 1'b0;
        st_q[i]    <= 1'b0;
        br_q[i]    <= 1'b0;
        jmp_q[i]   <= 1'b0;
        rd_q[i]    <= '0;
        val_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (flush_all) begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        done_q[i]  <= 1'b0;
        mis_q[i]   <= 1'b0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      // Later lanes overwrite earlier ones on an index collision
      for (int k = 0; k < N_CDB; k++) begin
        if (cdb_valid[k] && valid_q[cdb_rob_idx[k*IDXW +: IDXW]]) begin
          done_q[cdb_rob_idx[k*IDXW +: IDXW]] <= 1'b1;
          val_q[cdb_rob_idx[k*IDXW +: IDXW]]  <= cdb_val[k*32 +: 32];
        end
      end
      if (br_valid && valid_q[br_rob_idx] &&
          (br_q[br_rob_idx] || jmp_q[br_rob_idx])) begin
        done_q[br_rob_idx] <= 1'b1;
        mis_q[br_rob_idx]  <= br_mispredict;
        tgt_q[br_rob_idx]  <= br_target_pc;
        if (jmp_q[br_rob_idx])
          val_q[br_rob_idx] <= br_link_val;
      end
      if (cmt_valid) begin
        valid_q[hidx] <= 1'b0;
        done_q[hidx]  <= 1'b0;
        mis_q[hidx]   <= 1'b0;
      end
      if (alloc) begin
        valid_q[tidx] <= 1'b1;
        done_q[tidx]  <= iss_load_imm;
        mis_q[tidx]   <= 1'b0;
        val_q[tidx]   <= iss_imm_val;
        rd_q[tidx]    <= iss_dr;
        st_q[tidx]    <= iss_is_st;
        br_q[tidx]    <= iss_is_br;
        jmp_q[tidx]   <= iss_is_jump;
        tgt_q[tidx]   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_cdb.sv
// Directed checks on a 16x2 ROB, then randomized traffic on a 4x3 ROB
// compared against a program-order queue model.
module tb_rob_multi_cdb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: DEPTH=16, N_CDB=2 ----------------
  logic a_rst, a_iv, a_ir, a_li, a_st, a_br, a_jmp;
  logic [4:0]  a_dr;
  logic [31:0] a_imm;
  logic [3:0]  a_ridx;
  logic [1:0]  a_cv;
  logic [7:0]  a_ci;
  logic [63:0] a_cval;
  logic        a_brv, a_mis;
  logic [3:0]  a_bri;
  logic [31:0] a_tgt, a_link;
  logic [3:0]  a_lk1, a_lk2;
  logic        a_lv1, a_lv2;
  logic [31:0] a_lval1, a_lval2;
  logic        a_cmt, a_cst, a_fl;
  logic [4:0]  a_crd;
  logic [31:0] a_cval_o, a_fpc;
  logic [3:0]  a_cidx;
  logic [4:0]  a_cnt;

  rob_multi_cdb #(.DEPTH(16), .N_CDB(2)) dut_a (
    .clk(clk), .rst(a_rst),
    .iss_valid(a_iv), .iss_ready(a_ir), .iss_dr(a_dr),
    .iss_load_imm(a_li), .iss_imm_val(a_imm),
    .iss_is_st(a_st), .iss_is_br(a_br), .iss_is_jump(a_jmp),
    .iss_rob_idx(a_ridx),
    .cdb_valid(a_cv), .cdb_rob_idx(a_ci), .cdb_val(a_cval),
    .br_valid(a_brv), .br_rob_idx(a_bri), .br_mispredict(a_mis),
    .br_target_pc(a_tgt), .br_link_val(a_link),
    .lk_idx_1(a_lk1), .lk_idx_2(a_lk2),
    .lk_valid_1(a_lv1), .lk_valid_2(a_lv2),
    .lk_val_1(a_lval1), .lk_val_2(a_lval2),
    .cmt_valid(a_cmt), .cmt_rd(a_crd), .cmt_val(a_cval_o),
    .cmt_rob_idx(a_cidx), .cmt_is_st(a_cst),
    .flush_all(a_fl), .flush_pc(a_fpc), .count(a_cnt)
  );

  // ---------------- instance B: DEPTH=4, N_CDB=3 ----------------
  logic b_rst, b_iv, b_ir, b_li, b_st, b_br, b_jmp;
  logic [4:0]  b_dr;
  logic [31:0] b_imm;
  logic [1:0]  b_ridx;
  logic [2:0]  b_cv;
  logic [5:0]  b_ci;
  logic [95:0] b_cval;
  logic        b_brv, b_mis;
  logic [1:0]  b_bri;
  logic [31:0] b_tgt, b_link;
  logic [1:0]  b_lk1, b_lk2;
  logic        b_lv1, b_lv2;
  logic [31:0] b_lval1, b_lval2;
  logic        b_cmt, b_cst, b_fl;
  logic [4:0]  b_crd;
  logic [31:0] b_cval_o, b_fpc;
  logic [1:0]  b_cidx;
  logic [2:0]  b_cnt;

  rob_multi_cdb #(.DEPTH(4), .N_CDB(3)) dut_b (
    .clk(clk), .rst(b_rst),
    .iss_valid(b_iv), .iss_ready(b_ir), .iss_dr(b_dr),
    .iss_load_imm(b_li), .iss_imm_val(b_imm),
    .iss_is_st(b_st), .iss_is_br(b_br), .iss_is_jump(b_jmp),
    .iss_rob_idx(b_ridx),
    .cdb_valid(b_cv), .cdb_rob_idx(b_ci), .cdb_val(b_cval),
    .br_valid(b_brv), .br_rob_idx(b_bri), .br_mispredict(b_mis),
    .br_target_pc(b_tgt), .br_link_val(b_link),
    .lk_idx_1(b_lk1), .lk_idx_2(b_lk2),
    .lk_valid_1(b_lv1), .lk_valid_2(b_lv2),
    .lk_val_1(b_lval1), .lk_val_2(b_lval2),
    .cmt_valid(b_cmt), .cmt_rd(b_crd), .cmt_val(b_cval_o),
    .cmt_rob_idx(b_cidx), .cmt_is_st(b_cst),
    .flush_all(b_fl), .flush_pc(b_fpc), .count(b_cnt)
  );

  // Program-order model of in-flight instructions for instance B
  typedef struct {
    logic [1:0]  idx;
    logic [4:0]  rd;
    logic        done;
    logic [31:0] val;
    logic        st;
    logic        brj;
    logic        jmp;
    logic        mis;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];

  function automatic void exp_lk(input logic [1:0] idx, output logic known,
                                 output logic v, output logic [31:0] val);
    known = 1'b0; v = 1'b0; val = '0;
    foreach (q[i]) if (q[i].idx == idx) begin
      known = 1'b1; v = q[i].done; val = q[i].val;
    end
    if (!known) known = 1'b1;
    for (int k = 0; k < 3; k++)
      if (b_cv[k] && b_ci[k*2 +: 2] == idx) begin
        v = 1'b1; val = b_cval[k*32 +: 32];
      end
  endfunction

  initial begin
    int tail_m, commits, wraps, last_idx, p;
    logic [3:0] used;
    logic ecmt, efl, erdy, kn, ev;
    logic [31:0] eval;
    ent_t e;

    a_rst = 1; a_iv = 0; a_li = 0; a_st = 0; a_br = 0; a_jmp = 0;
    a_dr = 0; a_imm = 0; a_cv = 0; a_ci = 0; a_cval = 0;
    a_brv = 0; a_bri = 0; a_mis = 0; a_tgt = 0; a_link = 0;
    a_lk1 = 0; a_lk2 = 0;
    b_rst = 1; b_iv = 0; b_li = 0; b_st = 0; b_br = 0; b_jmp = 0;
    b_dr = 0; b_imm = 0; b_cv = 0; b_ci = 0; b_cval = 0;
    b_brv = 0; b_bri = 0; b_mis = 0; b_tgt = 0; b_link = 0;
    b_lk1 = 0; b_lk2 = 0;
    repeat (2) @(negedge clk);
    a_rst = 0;
    #1;
    chk("rst_ready", a_ir, 1);
    chk("rst_count", a_cnt, 0);
    chk("rst_cmt", a_cmt, 0);
    chk("rst_flush", a_fl, 0);
    chk("rst_idx", a_ridx, 0);
    chk("rst_lkv", a_lv1, 0);

    // three ALU ops
    for (int i = 0; i < 3; i++) begin
      a_iv = 1; a_dr = 5'(i + 1);
      #1 chk("t1_idx", a_ridx, i);
      @(negedge clk);
    end
    a_iv = 0;
    #1 chk("t1_count", a_cnt, 3);
    chk("t1_cmt", a_cmt, 0);

    // out-of-order CDB completion, in-order retire
    a_cv = 2'b10; a_ci = {4'd1, 4'd0}; a_cval = {32'hAA, 32'h0};
    #1 chk("t2_cmt0", a_cmt, 0);
    @(negedge clk);
    a_cv = 2'b01; a_ci = {4'd0, 4'd0}; a_cval = {32'h0, 32'h55};
    #1 chk("t2_cmt1", a_cmt, 0);
    @(negedge clk);
    a_cv = 0;
    #1 chk("t2_c1v", a_cmt, 1);
    chk("t2_c1rd", a_crd, 1);
    chk("t2_c1val", a_cval_o, 32'h55);
    @(negedge clk);
    #1 chk("t2_c2v", a_cmt, 1);
    chk("t2_c2rd", a_crd, 2);
    chk("t2_c2val", a_cval_o, 32'hAA);
    chk("t2_c2idx", a_cidx, 1);
    @(negedge clk);
    #1 chk("t2_c3v", a_cmt, 0);

    // lookup bypass
    a_lk1 = 2; a_lk2 = 1;
    #1 chk("t4_lkv_pre", a_lv1, 0);
    a_cv = 2'b01; a_ci = {4'd0, 4'd2}; a_cval = {32'h0, 32'h1234};
    #1 chk("t4_lkv", a_lv1, 1);
    chk("t4_lkval", a_lval1, 32'h1234);
    chk("t4_lkv2", a_lv2, 0);
    @(negedge clk);
    a_cv = 0;
    #1 chk("t4_cmtrd", a_crd, 3);
    chk("t4_cmtval", a_cval_o, 32'h1234);
    @(negedge clk);
    #1 chk("t4_count", a_cnt, 0);

    // fill to full (head/tail now at 3)
    for (int i = 0; i < 16; i++) begin
      a_iv = 1; a_dr = 5'(i + 4);
      @(negedge clk);
    end
    #1 chk("t3_full_rdy", a_ir, 0);
    chk("t3_full_cnt", a_cnt, 16);
    @(negedge clk);
    #1 chk("t3_17th", a_cnt, 16);
    a_cv = 2'b01; a_ci = {4'd0, 4'd3}; a_cval = {32'h0, 32'h77};
    @(negedge clk);
    a_cv = 0;
    #1 chk("t3_cmt", a_cmt, 1);
    chk("t3_rdy_cmt", a_ir, 0);
    @(negedge clk);
    #1 chk("t3_rdy_after", a_ir, 1);
    chk("t3_cnt_after", a_cnt, 15);
    a_iv = 0;
    a_rst = 1;
    @(negedge clk);
    a_rst = 0;
    #1 chk("mid_rst_cnt", a_cnt, 0);

    // mispredicted jal retires with its link value and flushes
    a_iv = 1; a_jmp = 1; a_dr = 5;
    @(negedge clk);
    a_jmp = 0; a_dr = 6;
    @(negedge clk);
    a_dr = 7;
    @(negedge clk);
    a_iv = 0;
    a_brv = 1; a_bri = 0; a_mis = 1; a_tgt = 32'h80; a_link = 32'h44;
    @(negedge clk);
    a_brv = 0; a_mis = 0;
    a_iv = 1; a_dr = 9;
    #1 chk("t5_cmt", a_cmt, 1);
    chk("t5_rd", a_crd, 5);
    chk("t5_val", a_cval_o, 32'h44);
    chk("t5_flush", a_fl, 1);
    chk("t5_pc", a_fpc, 32'h80);
    chk("t5_rdy", a_ir, 0);
    @(negedge clk);
    a_dr = 10;
    #1 chk("t5_cnt0", a_cnt, 0);
    chk("t5_idx0", a_ridx, 0);
    chk("t5_rdy1", a_ir, 1);
    @(negedge clk);
    a_iv = 0;
    #1 chk("t5_cnt1", a_cnt, 1);

    // randomized traffic on the small 3-lane ROB
    b_rst = 0;
    tail_m = 0; commits = 0; wraps = 0; last_idx = -1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      b_iv = ($urandom_range(0, 99) < 65);
      b_dr = 5'($urandom);
      b_li = ($urandom_range(0, 3) == 0);
      b_imm = $urandom;
      p = $urandom_range(0, 7);
      b_st = (p == 0); b_br = (p == 1); b_jmp = (p == 2);
      b_cv = 0; b_ci = 0; b_cval = 0; b_brv = 0; b_mis = 0;
      used = 0;
      if (q.size() > 0) begin
        p = $urandom_range(0, q.size() - 1);
        if (q[p].brj && !q[p].done && $urandom_range(0, 1) == 1) begin
          b_brv = 1; b_bri = q[p].idx;
          b_mis = ($urandom_range(0, 5) == 0);
          b_tgt = $urandom; b_link = $urandom;
          used[q[p].idx] = 1'b1;
        end
      end
      for (int k = 0; k < 3; k++) if (q.size() > 0) begin
        p = $urandom_range(0, q.size() - 1);
        if (!q[p].done && !used[q[p].idx] && $urandom_range(0, 1) == 1) begin
          b_cv[k] = 1'b1;
          b_ci[k*2 +: 2] = q[p].idx;
          b_cval[k*32 +: 32] = $urandom;
          used[q[p].idx] = 1'b1;
        end
      end
      b_lk1 = 2'($urandom); b_lk2 = 2'($urandom);
      #1;
      ecmt = (q.size() > 0) && q[0].done;
      efl  = ecmt && q[0].mis;
      erdy = (q.size() < 4) && !efl;
      chk("r_count", b_cnt, q.size());
      chk("r_ready", b_ir, erdy);
      chk("r_cmt", b_cmt, ecmt);
      chk("r_idx", b_ridx, tail_m % 4);
      chk("r_flush", b_fl, efl);
      exp_lk(b_lk1, kn, ev, eval);
      chk("r_lkv1", b_lv1, ev);
      if (ev) chk("r_lkval1", b_lval1, eval);
      exp_lk(b_lk2, kn, ev, eval);
      chk("r_lkv2", b_lv2, ev);
      if (ev) chk("r_lkval2", b_lval2, eval);
      if (ecmt) begin
        chk("r_crd", b_crd, q[0].rd);
        chk("r_cval", b_cval_o, q[0].val);
        chk("r_cidx", b_cidx, q[0].idx);
        chk("r_cst", b_cst, q[0].st);
        if (efl) chk("r_fpc", b_fpc, q[0].tgt);
        if (last_idx == 3 && q[0].idx == 0) wraps++;
        last_idx = q[0].idx;
        commits++;
      end
      if (efl) begin
        q.delete();
        tail_m = 0;
      end else begin
        if (ecmt) void'(q.pop_front());
        for (int k = 0; k < 3; k++) if (b_cv[k])
          foreach (q[i]) if (q[i].idx == b_ci[k*2 +: 2]) begin
            q[i].done = 1'b1; q[i].val = b_cval[k*32 +: 32];
          end
        if (b_brv) foreach (q[i]) if (q[i].idx == b_bri) begin
          q[i].done = 1'b1; q[i].mis = b_mis; q[i].tgt = b_tgt;
          if (q[i].jmp) q[i].val = b_link;
        end
        if (b_iv && erdy) begin
          e.idx = 2'(tail_m % 4); e.rd = b_dr; e.done = b_li;
          e.val = b_imm; e.st = b_st; e.brj = b_br || b_jmp;
          e.jmp = b_jmp; e.mis = 1'b0; e.tgt = '0;
          q.push_back(e);
          tail_m++;
        end
      end
      @(negedge clk);
    end
    chk("r_commits_ge40", 32'(commits >= 40), 1);
    chk("r_wrapped", 32'(wraps > 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
